// File: rtl/btn_db_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and
// default timing constants.
package btn_db_pkg;

  typedef enum logic [2:0] {
    ST_ZERO    = 3'd0,
    ST_WAIT1_1 = 3'd1,
    ST_WAIT1_2 = 3'd2,
    ST_WAIT1_3 = 3'd3,
    ST_ONE     = 3'd4,
    ST_WAIT0_1 = 3'd5,
    ST_WAIT0_2 = 3'd6,
    ST_WAIT0_3 = 3'd7
  } db_state_t;

  localparam int unsigned SAMPLE_W_DEF    = 19;
  localparam int unsigned REPEAT_DLY_DEF  = 32;
  localparam int unsigned REPEAT_RATE_DEF = 8;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running W-bit counter; m_tick is high for the one clk in which the
// count is all-ones. One instance can pace several debouncers.
module sample_tick_gen #(
  parameter int unsigned W = 19
) (
  input  logic clk,
  input  logic reset,
  output logic m_tick
);

  logic [W-1:0] cnt;

  // Free-running up counter, wraps to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign m_tick = (cnt == '1);

endmodule

// File: rtl/btn_debounce_tick.sv
// Button conditioner: 2-flop synchroniser, sampled-tick debounce FSM,
// registered level and press-tick outputs.
// Optional auto-repeat of db_tick while held: BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_tick
  import btn_db_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter int unsigned REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_RATE = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  if (REPEAT_RATE < 1 || REPEAT_DLY < REPEAT_RATE) begin : g_bad_cfg
    $error("btn_debounce_tick: need 1 <= REPEAT_RATE <= REPEAT_DLY");
  end

  logic      sw_meta, sw_s;
  logic      m_tick;
  db_state_t state, state_next;
  logic      level_next, press, rpt_tick;

  sample_tick_gen #(.W(SAMPLE_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .m_tick (m_tick)
  );

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= 1'b0;
      sw_s    <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ZERO;
    else        state <= state_next;
  end

  // Next-state logic; the synchronised input wins over m_tick.
  always_comb begin
    state_next = state;
    case (state)
      ST_ZERO:    if (sw_s) state_next = ST_WAIT1_1;
      ST_WAIT1_1: if (!sw_s) state_next = ST_ZERO; else if (m_tick) state_next = ST_WAIT1_2;
      ST_WAIT1_2: if (!sw_s) state_next = ST_ZERO; else if (m_tick) state_next = ST_WAIT1_3;
      ST_WAIT1_3: if (!sw_s) state_next = ST_ZERO; else if (m_tick) state_next = ST_ONE;
      ST_ONE:     if (!sw_s) state_next = ST_WAIT0_1;
      ST_WAIT0_1: if (sw_s) state_next = ST_ONE; else if (m_tick) state_next = ST_WAIT0_2;
      ST_WAIT0_2: if (sw_s) state_next = ST_ONE; else if (m_tick) state_next = ST_WAIT0_3;
      ST_WAIT0_3: if (sw_s) state_next = ST_ONE; else if (m_tick) state_next = ST_ZERO;
      default:    state_next = ST_ZERO;
    endcase
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    level_next = (state_next == ST_ONE)     || (state_next == ST_WAIT0_1) ||
                 (state_next == ST_WAIT0_2) || (state_next == ST_WAIT0_3);
    press      = (state == ST_WAIT1_3) && (state_next == ST_ONE);
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DLY + 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_RATE);

  logic [RW-1:0] rpt_cnt;

  // Repeat strobe on the m_tick that brings the count to REPEAT_DLY.
  always_comb begin
    rpt_tick = (state == ST_ONE) && m_tick && (rpt_cnt == RPT_LAST);
  end

  // Hitting REPEAT_DLY reloads DLY-RATE, so later strobes recur every
  // REPEAT_RATE m_ticks without a wide or modulo comparator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt <= '0;
    end else if (state == ST_ZERO || state == ST_WAIT1_1 ||
                 state == ST_WAIT1_2 || state == ST_WAIT1_3) begin
      rpt_cnt <= '0;
    end else if (state == ST_ONE && m_tick) begin
      rpt_cnt <= rpt_tick ? RPT_RELOAD : rpt_cnt + 1'b1;
    end
  end
`else
  // No auto-repeat in this build.
  always_comb begin
    rpt_tick = 1'b0;
  end
`endif

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      db_level <= level_next;
      db_tick  <= press | rpt_tick;
    end
  end

endmodule
